// File: rtl/alu_scheduler_if.sv
// Command, ALU and response signals shared by alu_scheduler and its environment.
// master is the scheduler's view; slave is the requesters/ALU/consumer view.
interface alu_scheduler_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [1:0]            req0_opcode;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [1:0]            req1_opcode;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;

    logic [1:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [1:0]            rsp_opcode;
    logic [DATA_WIDTH-1:0] rsp_data;

    logic                  busy;

    modport master (
        input  req0_valid, req0_opcode, req0_a, req0_b,
        input  req1_valid, req1_opcode, req1_a, req1_b,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_opcode, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_opcode, rsp_data,
        output busy
    );

    modport slave (
        output req0_valid, req0_opcode, req0_a, req0_b,
        output req1_valid, req1_opcode, req1_a, req1_b,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_opcode, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_opcode, rsp_data,
        input  busy
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin two-requester front end for a shared fixed-latency ALU.
// One operation in flight: grant, hold operands, capture result, respond.
module alu_scheduler #(
    parameter int DATA_WIDTH  = 256,
    parameter int ALU_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_scheduler_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ALU_LATENCY);

    state_t                state;
    state_t                state_next;
    logic                  last_grant;
    logic                  grant;
    logic                  grant_id;
    logic                  last_cycle;
    logic [3:0]            cnt;
    logic [1:0]            alu_opcode;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic                  rsp_id;
    logic [1:0]            rsp_opcode;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign last_cycle = (cnt == 4'd1);

    // Arbitration: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant    = 1'b0;
        grant_id = 1'b0;
        if (!rst && state == IDLE) begin
            grant = bus.req0_valid | bus.req1_valid;
            if (bus.req0_valid && bus.req1_valid) begin
                grant_id = ~last_grant;
            end else begin
                grant_id = bus.req1_valid;
            end
        end
    end

    // Next-state logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant) state_next = EXEC;
            EXEC:    if (last_cycle) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch on grant, latency countdown, result capture, fairness pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt        <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_id     <= 1'b0;
            rsp_opcode <= '0;
            rsp_data   <= '0;
        end else begin
            if (grant) begin
                alu_opcode <= grant_id ? bus.req1_opcode : bus.req0_opcode;
                alu_a      <= grant_id ? bus.req1_a : bus.req0_a;
                alu_b      <= grant_id ? bus.req1_b : bus.req0_b;
                rsp_opcode <= grant_id ? bus.req1_opcode : bus.req0_opcode;
                rsp_id     <= grant_id;
                cnt        <= CNT_LOAD;
            end else if (state == EXEC) begin
                cnt <= cnt - 4'd1;
                if (last_cycle) begin
                    rsp_data <= bus.alu_result;
                end
            end
            if (state == RESP && bus.rsp_ready) begin
                last_grant <= rsp_id;
            end
        end
    end

    assign bus.req0_ready = grant & ~grant_id;
    assign bus.req1_ready = grant & grant_id;
    assign bus.alu_opcode = alu_opcode;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id;
    assign bus.rsp_opcode = rsp_opcode;
    assign bus.rsp_data   = rsp_data;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: timestamp-based transaction model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_scheduler;
    localparam int W = 256;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   gq_cyc[$];
    bit   gq_id[$];

    alu_scheduler_if #(.DATA_WIDTH(W)) bus ();

    alu_scheduler #(.DATA_WIDTH(W), .ALU_LATENCY(L)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_ref(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int s;
        logic [W-1:0] r;
        s = int'(b % W);
        r = '0;
        case (op)
            2'b00: r[0] = ^a;
            2'b01: r = (a >> s) | (a << (W - s));
            2'b10: r = (a << s) | (a >> (W - s));
            default: for (int i = 0; i < W; i++) r = r + W'(a[i]);
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Bench-side ALU: combinational, the scheduler samples after its hold time.
    assign bus.alu_result = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b);

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // Transaction model: one op in flight, accepted at m_acc, response after L cycles.
    bit           m_on = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    int           m_acc = 0;
    bit           m_id = 1'b0;
    logic [1:0]   m_op = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [1:0]   m_alu_op = '0;
    logic [W-1:0] m_alu_a = '0;
    logic [W-1:0] m_alu_b = '0;

    always @(negedge clk) begin
        bit e_r0;
        bit e_r1;
        bit in_resp;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        in_resp = m_busy && (cyc > m_acc + L);
        if (!m_busy && !rst) begin
            e_r0 = bus.req0_valid && (!bus.req1_valid || m_last);
            e_r1 = bus.req1_valid && (!bus.req0_valid || !m_last);
        end
        if (m_on) begin
            check("m_ready0", W'(bus.req0_ready), W'(e_r0));
            check("m_ready1", W'(bus.req1_ready), W'(e_r1));
            check("m_busy", W'(bus.busy), W'(m_busy));
            check("m_rsp_valid", W'(bus.rsp_valid), W'(in_resp));
            check("m_alu_opcode", W'(bus.alu_opcode), W'(m_alu_op));
            check("m_alu_a", bus.alu_a, m_alu_a);
            check("m_alu_b", bus.alu_b, m_alu_b);
            if (in_resp) begin
                check("m_rsp_id", W'(bus.rsp_id), W'(m_id));
                check("m_rsp_opcode", W'(bus.rsp_opcode), W'(m_op));
                check("m_rsp_data", bus.rsp_data, alu_ref(m_op, m_a, m_b));
            end
        end
        if (rst) begin
            m_on = 1'b1;
            m_busy = 1'b0;
            m_last = 1'b1;
            m_alu_op = '0;
            m_alu_a = '0;
            m_alu_b = '0;
        end else if (e_r0 || e_r1) begin
            m_busy = 1'b1;
            m_acc = cyc;
            m_id = e_r1;
            m_op = e_r1 ? bus.req1_opcode : bus.req0_opcode;
            m_a = e_r1 ? bus.req1_a : bus.req0_a;
            m_b = e_r1 ? bus.req1_b : bus.req0_b;
            m_alu_op = m_op;
            m_alu_a = m_a;
            m_alu_b = m_b;
        end else if (in_resp && bus.rsp_ready) begin
            m_busy = 1'b0;
            m_last = m_id;
        end
    end

    task automatic send0(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_opcode = op;
        bus.req0_a = a;
        bus.req0_b = b;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (bus.req0_ready === 1'b1) begin
                got = 1'b1;
                gq_cyc.push_back(cyc);
                gq_id.push_back(1'b0);
            end
        end
        if (!got) timeout("req0_handshake");
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
    endtask

    task automatic send1(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got = 1'b0;
        bus.req1_valid = 1'b1;
        bus.req1_opcode = op;
        bus.req1_a = a;
        bus.req1_b = b;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (bus.req1_ready === 1'b1) begin
                got = 1'b1;
                gq_cyc.push_back(cyc);
                gq_id.push_back(1'b1);
            end
        end
        if (!got) timeout("req1_handshake");
        @(posedge clk);
        #1;
        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) return;
        end
        timeout("wait_rsp");
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) done = 1'b1;
        end
        if (!done) timeout("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        check({tag, "_busy"}, W'(bus.busy), W'(0));
        check({tag, "_rsp_valid"}, W'(bus.rsp_valid), W'(0));
        check({tag, "_alu_opcode"}, W'(bus.alu_opcode), W'(0));
        check({tag, "_alu_a"}, bus.alu_a, '0);
        check({tag, "_alu_b"}, bus.alu_b, '0);
        check({tag, "_rsp_id"}, W'(bus.rsp_id), W'(0));
        check({tag, "_rsp_opcode"}, W'(bus.rsp_opcode), W'(0));
        check({tag, "_rsp_data"}, bus.rsp_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a1;
        logic [W-1:0] top;
        bus.req0_valid = 1'b1;
        bus.req0_opcode = '0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_valid = 1'b0;
        bus.req1_opcode = '0;
        bus.req1_a = '0;
        bus.req1_b = '0;
        bus.rsp_ready = 1'b1;
        top = '0;
        top[W-1] = 1'b1;

        // reset: ready held low while rst is high, then reset values
        @(negedge clk);
        check("rst_ready0", W'(bus.req0_ready), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");
        check("rst_ready1", W'(bus.req1_ready), W'(0));

        // single POPCOUNT command, cycle-exact
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req0_opcode = 2'b11;
        bus.req0_a = W'('hFF);
        bus.req0_b = '0;
        @(negedge clk);
        check("one_ready0", W'(bus.req0_ready), W'(1));
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("one_c1_opcode", W'(bus.alu_opcode), W'(3));
        check("one_c1_busy", W'(bus.busy), W'(1));
        check("one_c1_rsp_valid", W'(bus.rsp_valid), W'(0));
        @(negedge clk);
        check("one_c2_opcode", W'(bus.alu_opcode), W'(3));
        check("one_c2_rsp_valid", W'(bus.rsp_valid), W'(0));
        @(negedge clk);
        check("one_c3_rsp_valid", W'(bus.rsp_valid), W'(1));
        check("one_c3_rsp_id", W'(bus.rsp_id), W'(0));
        check("one_c3_rsp_opcode", W'(bus.rsp_opcode), W'(3));
        check("one_c3_rsp_data", bus.rsp_data, W'(8));
        @(negedge clk);
        check("one_c4_busy", W'(bus.busy), W'(0));

        // tie after reset: requester 0 first, then requester 1
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fork
            send0(2'b01, W'('hF0), W'(4));
            send1(2'b10, top, W'(1));
            begin
                @(negedge clk);
                check("tie_ready0", W'(bus.req0_ready), W'(1));
                check("tie_ready1", W'(bus.req1_ready), W'(0));
                wait_rsp();
                check("tie_rsp0_id", W'(bus.rsp_id), W'(0));
                check("tie_rsp0_data", bus.rsp_data, W'('h0F));
                @(negedge clk);
                wait_rsp();
                check("tie_rsp1_id", W'(bus.rsp_id), W'(1));
                check("tie_rsp1_data", bus.rsp_data, W'(1));
            end
        join
        wait_idle();

        // sustained contention: strict alternation, issue every L+2 cycles
        gq_cyc.delete();
        gq_id.delete();
        fork
            for (int k = 0; k < 8; k++) send0(2'(k), rnd(), W'(k * 37));
            for (int k = 0; k < 8; k++) send1(2'(3 - k), rnd(), W'(k * 53 + 1));
        join
        wait_idle();
        check("ctn_count", W'(gq_cyc.size()), W'(16));
        for (int i = 1; i < gq_cyc.size(); i++) begin
            check("ctn_alternate", W'(gq_id[i]), W'(!gq_id[i-1]));
            check("ctn_interval", W'(gq_cyc[i] - gq_cyc[i-1]), W'(L + 2));
        end

        // backpressure: response held, requester 1 waits
        bus.rsp_ready = 1'b0;
        send0(2'b11, W'('h0F0F), '0);
        fork
            send1(2'b00, W'(7), '0);
            begin : bp_chk
                logic [W-1:0] d0;
                wait_rsp();
                d0 = bus.rsp_data;
                check("bp_data_lit", d0, W'(8));
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_valid", W'(bus.rsp_valid), W'(1));
                    check("bp_id", W'(bus.rsp_id), W'(0));
                    check("bp_data", bus.rsp_data, d0);
                    check("bp_ready", W'(bus.req0_ready | bus.req1_ready), W'(0));
                    check("bp_busy", W'(bus.busy), W'(1));
                end
                @(posedge clk);
                #1;
                bus.rsp_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("bp_idle_busy", W'(bus.busy), W'(0));
                check("bp_idle_ready1", W'(bus.req1_ready), W'(1));
            end
        join
        wait_idle();

        // operand stability while the requester changes its payload
        a1 = rnd();
        send0(2'b01, a1, W'(8));
        bus.req0_a = ~a1;
        @(negedge clk);
        check("hold_c1_a", bus.alu_a, a1);
        @(negedge clk);
        check("hold_c2_a", bus.alu_a, a1);
        check("hold_c2_opcode", W'(bus.alu_opcode), W'(1));
        wait_idle();

        // reset in the second EXEC cycle aborts the operation
        send0(2'b11, rnd(), rnd());
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid");
        @(posedge clk);
        #1;
        fork
            send0(2'b00, W'(3), '0);
            send1(2'b00, W'(1), '0);
            begin
                @(negedge clk);
                check("mid_tie_ready0", W'(bus.req0_ready), W'(1));
                check("mid_tie_ready1", W'(bus.req1_ready), W'(0));
            end
        join
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
